// File: rtl/instruction_fetcher.sv
// Instruction fetch front end: walks the PC, issues one 4-byte fetch at a
// time to the cache instruction port, and buffers returned words with their
// PCs in a small circular queue that feeds the decoder.
module instruction_fetcher #(
    parameter int          QUEUE_BIT = 2,
    parameter logic [31:0] RESET_PC  = 32'h0
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    output logic        i_waiting,
    output logic [31:0] i_addr,
    input  logic [31:0] i_result,
    input  logic        i_m_ready,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready,
    input  logic        flush,
    input  logic [31:0] flush_pc
);

    localparam int DEPTH = 1 << QUEUE_BIT;

    localparam logic [QUEUE_BIT-1:0] PTR_ONE  = QUEUE_BIT'(1);
    localparam logic [QUEUE_BIT:0]   CNT_ONE  = (QUEUE_BIT + 1)'(1);
    localparam logic [QUEUE_BIT+1:0] FILL_MAX = (QUEUE_BIT + 2)'(DEPTH);

    // IDLE: no request out. REQ: request for pc in flight. DRAIN: a request
    // made before a redirect is still in flight and its word will be dropped.
    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DRAIN
    } state_t;

    state_t                 state;
    logic [31:0]            pc;
    logic [QUEUE_BIT-1:0]   head;
    logic [QUEUE_BIT-1:0]   tail;
    logic [QUEUE_BIT:0]     count;
    logic [31:0]            q_pc   [DEPTH];
    logic [31:0]            q_inst [DEPTH];

    logic                   done;
    logic                   pop;
    logic                   push;
    logic                   space;
    logic [QUEUE_BIT+1:0]   fill;
    logic [31:0]            pc_plus4;
    logic [31:0]            pc_target;

    assign done      = i_waiting & i_m_ready;
    assign pop       = inst_valid & inst_ready & ~flush;
    assign push      = done & (state == REQ) & ~flush;
    // A pop in the same cycle is not credited, so one slot is always free
    // for whichever request is still in flight.
    assign fill      = {1'b0, count} + {{(QUEUE_BIT + 1){1'b0}}, push};
    assign space     = fill < FILL_MAX;
    assign pc_plus4  = pc + 32'd4;
    // Where the next fetch should go if one is issued this cycle.
    assign pc_target = flush ? flush_pc : pc;

    // Queue head is read straight from storage; no bypass of the incoming word.
    assign inst_valid = (count != '0);
    assign inst       = q_inst[head];
    assign inst_pc    = q_pc[head];

    // Fetch request sequencing and PC tracking.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state     <= IDLE;
            pc        <= RESET_PC;
            i_waiting <= 1'b0;
            i_addr    <= 32'h0;
        end else if (rdy_in) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // branch below sees the pre-edge values of pc, state and count.
            case (state)
                IDLE: begin
                    if (flush) pc <= flush_pc;
                    if (space) begin
                        i_waiting <= 1'b1;
                        i_addr    <= pc_target;
                        state     <= REQ;
                    end
                end
                REQ: begin
                    if (done && !flush) begin
                        pc <= pc_plus4;
                        if (space) begin
                            i_addr <= pc_plus4;
                        end else begin
                            i_waiting <= 1'b0;
                            state     <= IDLE;
                        end
                    end else if (done) begin
                        pc     <= flush_pc;
                        i_addr <= flush_pc;
                    end else if (flush) begin
                        pc    <= flush_pc;
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (flush) pc <= flush_pc;
                    if (done) begin
                        i_addr <= pc_target;
                        state  <= REQ;
                    end
                end
                default: begin
                    state     <= IDLE;
                    i_waiting <= 1'b0;
                end
            endcase
        end
    end

    // Queue pointers and occupancy; a redirect empties the queue.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (rdy_in) begin
            if (flush) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (push) tail <= tail + PTR_ONE;
                if (pop)  head <= head + PTR_ONE;
                if (push && !pop)      count <= count + CNT_ONE;
                else if (pop && !push) count <= count - CNT_ONE;
            end
        end
    end

    // Queue storage write of the returned word and its PC.
    // NOTE: storage has no reset; count gates every read so stale contents
    // are never observed, and leaving it unreset keeps it a plain RAM.
    always_ff @(posedge clk_in) begin
        if (rdy_in && push) begin
            q_pc[tail]   <= pc;
            q_inst[tail] <= i_result;
        end
    end

endmodule

// File: tb/tb_instruction_fetcher.sv
// Self-checking bench for instruction_fetcher: directed scenarios followed by
// a randomized run, all compared against a transaction-level model that
// tracks the outstanding request, the redirect target and a queue of
// delivered {pc, word} entries.
module tb_instruction_fetcher;

    localparam int          QUEUE_BIT = 2;
    localparam int          DEPTH     = 1 << QUEUE_BIT;
    localparam logic [31:0] RESET_PC  = 32'h0;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        i_waiting;
    logic [31:0] i_addr;
    logic [31:0] i_result;
    logic        i_m_ready;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;
    logic        flush;
    logic [31:0] flush_pc;

    instruction_fetcher #(
        .QUEUE_BIT (QUEUE_BIT),
        .RESET_PC  (RESET_PC)
    ) dut (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .rdy_in     (rdy_in),
        .i_waiting  (i_waiting),
        .i_addr     (i_addr),
        .i_result   (i_result),
        .i_m_ready  (i_m_ready),
        .inst_valid (inst_valid),
        .inst       (inst),
        .inst_pc    (inst_pc),
        .inst_ready (inst_ready),
        .flush      (flush),
        .flush_pc   (flush_pc)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
    } entry_t;

    // Reference model state
    entry_t      m_q[$];
    logic [31:0] m_pc;
    logic [31:0] m_addr;
    bit          m_out;
    bit          m_stale;

    // Cache model
    int          lat;
    logic [31:0] miss_addr;
    int          miss_lat;
    bit          rand_lat;

    int vectors     = 0;
    int miscompares = 0;

    function automatic logic [31:0] cache_word(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    function automatic int pick_lat(input logic [31:0] a);
        if (a == miss_addr) return miss_lat;
        if (rand_lat) return int'($urandom_range(0, 3));
        return 0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        check("i_waiting", 32'(i_waiting), 32'(m_out));
        check("i_addr", i_addr, m_addr);
        check("inst_valid", 32'(inst_valid), 32'(m_q.size() != 0));
        if (m_q.size() != 0) begin
            check("inst_pc", inst_pc, m_q[0].pc);
            check("inst", inst, m_q[0].word);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_pc    = RESET_PC;
        m_addr  = 32'h0;
        m_out   = 1'b0;
        m_stale = 1'b0;
        lat     = 0;
    endtask

    task automatic do_reset();
        rst_in     = 1'b1;
        rdy_in     = 1'b1;
        flush      = 1'b0;
        flush_pc   = 32'h0;
        inst_ready = 1'b0;
        i_m_ready  = 1'b0;
        i_result   = 32'h0;
        repeat (2) @(negedge clk_in);
        rst_in = 1'b0;
        model_reset();
        compare_all();
    endtask

    // One clock: present the cache response, advance the model by the
    // fetcher's rules, let the DUT take the edge, then compare.
    task automatic tick();
        bit done, push, pop, space, was_out;
        i_m_ready = m_out && (lat == 0);
        i_result  = cache_word(m_addr);
        if (rdy_in) begin
            was_out = m_out;
            done    = m_out && i_m_ready;
            pop     = (m_q.size() != 0) && inst_ready && !flush;
            push    = done && !m_stale && !flush;
            space   = (m_q.size() + int'(push)) < DEPTH;
            if (flush) begin
                m_q.delete();
            end else begin
                if (pop) void'(m_q.pop_front());
                if (push) m_q.push_back('{m_addr, cache_word(m_addr)});
            end
            if (!m_out) begin
                if (flush) m_pc = flush_pc;
                if (space) begin
                    m_out  = 1'b1;
                    m_addr = m_pc;
                end
            end else if (!m_stale) begin
                if (done && !flush) begin
                    m_pc = m_pc + 32'd4;
                    if (space) m_addr = m_pc;
                    else m_out = 1'b0;
                end else if (done) begin
                    m_pc   = flush_pc;
                    m_addr = flush_pc;
                end else if (flush) begin
                    m_pc    = flush_pc;
                    m_stale = 1'b1;
                end
            end else begin
                if (flush) m_pc = flush_pc;
                if (done) begin
                    m_addr  = m_pc;
                    m_stale = 1'b0;
                end
            end
            if (m_out && (done || !was_out)) lat = pick_lat(m_addr);
            else if (lat > 0) lat--;
        end
        @(posedge clk_in);
        @(negedge clk_in);
        compare_all();
    endtask

    initial begin
        miss_addr = 32'hFFFF_FFFF;
        miss_lat  = 0;
        rand_lat  = 1'b0;

        // Streaming with a hitting cache and an always-ready decoder
        do_reset();
        inst_ready = 1'b1;
        tick();
        check("t1_first_waiting", 32'(i_waiting), 32'h1);
        check("t1_first_addr", i_addr, 32'h0);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("t1_inst_pc", inst_pc, 32'(k * 4));
            check("t1_inst", inst, 32'(k * 4) ^ 32'hA5A5_0000);
        end

        // Decoder stalled: queue fills to four, fetch stops, then resumes
        do_reset();
        inst_ready = 1'b0;
        repeat (5) tick();
        check("t2_full_waiting", 32'(i_waiting), 32'h0);
        check("t2_full_addr", i_addr, 32'hC);
        repeat (3) tick();
        check("t2_hold_waiting", 32'(i_waiting), 32'h0);
        check("t2_hold_addr", i_addr, 32'hC);
        check("t2_hold_pc", inst_pc, 32'h0);
        inst_ready = 1'b1;
        tick();
        check("t2_pop1_pc", inst_pc, 32'h4);
        check("t2_pop1_waiting", 32'(i_waiting), 32'h0);
        tick();
        check("t2_reissue_waiting", 32'(i_waiting), 32'h1);
        check("t2_reissue_addr", i_addr, 32'h10);
        check("t2_pop2_pc", inst_pc, 32'h8);
        tick();
        check("t2_pop3_pc", inst_pc, 32'hC);
        tick();
        check("t2_pop4_pc", inst_pc, 32'h10);

        // Redirect during a five-cycle miss on address 8
        do_reset();
        inst_ready = 1'b0;
        miss_addr  = 32'h8;
        miss_lat   = 4;
        repeat (3) tick();
        check("t3_miss_addr", i_addr, 32'h8);
        tick();
        flush    = 1'b1;
        flush_pc = 32'h100;
        tick();
        flush = 1'b0;
        check("t3_flush_valid", 32'(inst_valid), 32'h0);
        check("t3_flush_addr", i_addr, 32'h8);
        check("t3_flush_waiting", 32'(i_waiting), 32'h1);
        repeat (2) tick();
        check("t3_drain_addr", i_addr, 32'h8);
        check("t3_drain_valid", 32'(inst_valid), 32'h0);
        tick();
        check("t3_redirect_addr", i_addr, 32'h100);
        check("t3_redirect_waiting", 32'(i_waiting), 32'h1);
        check("t3_redirect_valid", 32'(inst_valid), 32'h0);
        miss_addr = 32'hFFFF_FFFF;
        tick();
        check("t3_first_valid", 32'(inst_valid), 32'h1);
        check("t3_first_pc", inst_pc, 32'h100);

        // Redirect on the same edge as a hit for 0x20
        do_reset();
        inst_ready = 1'b1;
        for (int n = 0; n < 40 && !(i_waiting && i_addr == 32'h20); n++) tick();
        check("t4_reach_0x20", i_addr, 32'h20);
        flush    = 1'b1;
        flush_pc = 32'h40;
        tick();
        flush = 1'b0;
        check("t4_waiting", 32'(i_waiting), 32'h1);
        check("t4_addr", i_addr, 32'h40);
        check("t4_valid", 32'(inst_valid), 32'h0);
        tick();
        check("t4_first_valid", 32'(inst_valid), 32'h1);
        check("t4_first_pc", inst_pc, 32'h40);

        // Global stall in the middle of a miss with a ready decoder
        do_reset();
        inst_ready = 1'b0;
        miss_addr  = 32'h8;
        miss_lat   = 6;
        repeat (3) tick();
        inst_ready = 1'b1;
        rdy_in     = 1'b0;
        repeat (3) begin
            tick();
            check("t5_stall_valid", 32'(inst_valid), 32'h1);
            check("t5_stall_pc", inst_pc, 32'h0);
            check("t5_stall_addr", i_addr, 32'h8);
            check("t5_stall_waiting", 32'(i_waiting), 32'h1);
        end
        rdy_in = 1'b1;
        tick();
        check("t5_resume_pc", inst_pc, 32'h4);

        // Asynchronous reset while a request is outstanding
        #2 rst_in = 1'b1;
        #1;
        check("t6_async_waiting", 32'(i_waiting), 32'h0);
        check("t6_async_valid", 32'(inst_valid), 32'h0);
        check("t6_async_addr", i_addr, 32'h0);
        @(negedge clk_in);
        rst_in    = 1'b0;
        miss_addr = 32'hFFFF_FFFF;
        model_reset();
        compare_all();
        tick();
        check("t6_restart_waiting", 32'(i_waiting), 32'h1);
        check("t6_restart_addr", i_addr, RESET_PC);

        // Randomized traffic: stalls, redirects (incl. near wrap, unaligned),
        // variable cache latency and a bursty decoder
        do_reset();
        rand_lat  = 1'b1;
        miss_addr = 32'hFFFF_FFFF;
        for (int n = 0; n < 3000; n++) begin
            rdy_in     = ($urandom_range(0, 9) != 0);
            flush      = ($urandom_range(0, 11) == 0);
            flush_pc   = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF))
                                                     : $urandom;
            inst_ready = ($urandom_range(0, 2) != 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
